// File: rtl/fp_issue_sched_pkg.sv
// Shared encodings for the FP issue scheduler: op classes, unit latencies and
// the writeback reservation-vector width.
`ifndef RS_FPU_LEN
`define RS_FPU_LEN 32
`endif
`ifndef SPEC_STATES
`define SPEC_STATES 4
`endif

package fp_sched_pkg;
  typedef enum logic [1:0] {
    CLS_FMA  = 2'b00,
    CLS_DIV  = 2'b01,
    CLS_MISC = 2'b10,
    CLS_ILL  = 2'b11
  } fp_class_e;

  localparam int FMA_LAT_DEF  = 4;
  localparam int DIV_LAT_DEF  = 12;
  localparam int MISC_LAT_DEF = 1;
  localparam int WB_VEC_W     = 32;
endpackage

// File: rtl/fp_issue_sched_if.sv
// Request/grant and unit-issue bundle between the FP reservation station
// (master) and the FP issue scheduler (slave).
`ifndef RS_FPU_LEN
`define RS_FPU_LEN 32
`endif
`ifndef SPEC_STATES
`define SPEC_STATES 4
`endif

interface fp_issue_sched_if #(
  parameter int ISSUE_REQ   = 2,
  parameter int ENTRY_LEN   = `RS_FPU_LEN,
  parameter int SPEC_STATES = `SPEC_STATES
);
  logic                                  stall, flush, kill_en, update_killmask;
  logic [SPEC_STATES-1:0]                fubr_spectag;
  logic [ISSUE_REQ-1:0]                  req_valid;
  logic [ISSUE_REQ-1:0][ENTRY_LEN-1:0]   req_entry;
  logic [ISSUE_REQ-1:0][1:0]             req_class;
  logic [ISSUE_REQ-1:0][SPEC_STATES-1:0] req_killmask;
  logic [ISSUE_REQ-1:0]                  req_issued;
  logic                                  fma_valid, div_valid, misc_valid, div_busy;
  logic [ENTRY_LEN-1:0]                  fma_entry, div_entry, misc_entry;

  modport master (
    output stall, flush, kill_en, update_killmask, fubr_spectag,
           req_valid, req_entry, req_class, req_killmask,
    input  req_issued, fma_valid, fma_entry, div_valid, div_entry,
           misc_valid, misc_entry, div_busy
  );
  modport slave (
    input  stall, flush, kill_en, update_killmask, fubr_spectag,
           req_valid, req_entry, req_class, req_killmask,
    output req_issued, fma_valid, fma_entry, div_valid, div_entry,
           misc_valid, misc_entry, div_busy
  );
endinterface

// File: rtl/fp_issue_sched_div_tracker.sv
// Occupancy tracker for the iterative divider: down-counter, busy flag and the
// killmask of the in-flight divide.
module fp_div_tracker #(
  parameter int DIV_LAT     = 12,
  parameter int SPEC_STATES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   kill_en,
  input  logic                   update_killmask,
  input  logic [SPEC_STATES-1:0] fubr_spectag,
  input  logic                   grant,
  input  logic [SPEC_STATES-1:0] grant_km,
  output logic                   busy
);
  localparam int CW = $clog2(DIV_LAT + 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SPEC_STATES-1:0] km_q, km_d;

  assign busy = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    km_d  = km_q;
    if (!stall) begin
      if (grant) begin
        cnt_d = CW'(DIV_LAT);
        km_d  = grant_km;
      end else if (busy) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
    // A mispredict squashes the in-flight divide regardless of stall.
    if (kill_en && busy && |(km_q & fubr_spectag)) cnt_d = '0;
    if (update_killmask) km_d = km_d & ~fubr_spectag;
    if (flush) begin
      cnt_d = '0;
      km_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      km_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      km_q  <= km_d;
    end
  end
endmodule

// File: rtl/fp_issue_sched.sv
// FP issue scheduler: same-cycle in-order-priority grant of RS requests to the
// FMA/DIV/MISC units with writeback-bus slot reservation. FP_SCHED_PERFCNT_EN adds perf counters.
`ifndef RS_FPU_LEN
`define RS_FPU_LEN 32
`endif
`ifndef SPEC_STATES
`define SPEC_STATES 4
`endif

module fp_issue_sched
  import fp_sched_pkg::*;
#(
  parameter int ISSUE_REQ   = 2,
  parameter int ENTRY_LEN   = `RS_FPU_LEN,
  parameter int SPEC_STATES = `SPEC_STATES,
  parameter int FMA_LAT     = FMA_LAT_DEF,
  parameter int DIV_LAT     = DIV_LAT_DEF,
  parameter int MISC_LAT    = MISC_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_issue_sched_if.slave  bus
`ifdef FP_SCHED_PERFCNT_EN
  ,
  output logic [31:0]      perf_struct_stall,
  output logic [31:0]      perf_wb_conflict
`endif
);
  typedef struct packed {
    logic                   vld;
    logic [ENTRY_LEN-1:0]   entry;
    logic [SPEC_STATES-1:0] km;
  } iss_t;

  iss_t [2:0]             iss_q, iss_d;
  logic [WB_VEC_W-1:0]    rv_q, rv_d, rv_w;
  logic [ISSUE_REQ-1:0]   grant;
  logic [3:0]             taken;
  logic                   div_busy, div_grant;
  logic [SPEC_STATES-1:0] div_km;
  logic [1:0]             cls;
  int                     slot;
  logic                   req_ok, unit_free, wb_free;
`ifdef FP_SCHED_PERFCNT_EN
  logic [31:0]            perf_struct_q, perf_struct_d, perf_wb_q, perf_wb_d;
`endif

  function automatic int slot_of(input logic [1:0] c);
    case (c)
      CLS_FMA: return 1 + FMA_LAT;
      CLS_DIV: return 1 + DIV_LAT;
      default: return 1 + MISC_LAT;
    endcase
  endfunction

  always_comb begin
    rv_w      = rv_q;
    grant     = '0;
    taken     = '0;
    div_grant = 1'b0;
    div_km    = '0;
    iss_d     = iss_q;
    cls       = '0;
    slot      = 0;
    req_ok    = 1'b0;
    unit_free = 1'b0;
    wb_free   = 1'b0;
`ifdef FP_SCHED_PERFCNT_EN
    perf_struct_d = perf_struct_q;
    perf_wb_d     = perf_wb_q;
`endif
    if (!bus.stall) for (int u = 0; u < 3; u++) iss_d[u].vld = 1'b0;

    // rv_w accumulates this cycle's grants so higher ports see lower ports' slots.
    for (int p = 0; p < ISSUE_REQ; p++) begin
      cls       = bus.req_class[p];
      slot      = slot_of(cls);
      unit_free = (cls == CLS_DIV) ? !(div_busy || taken[CLS_DIV]) : !taken[cls];
      wb_free   = !rv_w[slot];
      req_ok    = rst_n && !bus.stall && !bus.flush && bus.req_valid[p] && (cls != CLS_ILL)
                  && !(bus.kill_en && |(bus.req_killmask[p] & bus.fubr_spectag));
      if (req_ok && unit_free && wb_free) begin
        grant[p]   = 1'b1;
        taken[cls] = 1'b1;
        rv_w[slot] = 1'b1;
        iss_d[cls] = '{vld: 1'b1, entry: bus.req_entry[p], km: bus.req_killmask[p]};
        if (cls == CLS_DIV) begin
          div_grant = 1'b1;
          div_km    = bus.req_killmask[p];
        end
      end
`ifdef FP_SCHED_PERFCNT_EN
      else if (req_ok && !unit_free) perf_struct_d = perf_struct_d + 32'd1;
      else if (req_ok)               perf_wb_d     = perf_wb_d + 32'd1;
`endif
    end

    for (int u = 0; u < 3; u++) begin
      if (bus.kill_en && |(iss_d[u].km & bus.fubr_spectag)) iss_d[u].vld = 1'b0;
      if (bus.update_killmask) iss_d[u].km = iss_d[u].km & ~bus.fubr_spectag;
    end

    rv_d = bus.stall ? rv_q : (rv_w >> 1);
    if (bus.flush) begin
      rv_d  = '0;
      iss_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q  <= '0;
      iss_q <= '0;
    end else begin
      rv_q  <= rv_d;
      iss_q <= iss_d;
    end
  end

`ifdef FP_SCHED_PERFCNT_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_struct_q <= '0;
      perf_wb_q     <= '0;
    end else begin
      perf_struct_q <= perf_struct_d;
      perf_wb_q     <= perf_wb_d;
    end
  end
  assign perf_struct_stall = perf_struct_q;
  assign perf_wb_conflict  = perf_wb_q;
`endif

  fp_div_tracker #(.DIV_LAT(DIV_LAT), .SPEC_STATES(SPEC_STATES)) u_div_trk (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (bus.stall),
    .flush           (bus.flush),
    .kill_en         (bus.kill_en),
    .update_killmask (bus.update_killmask),
    .fubr_spectag    (bus.fubr_spectag),
    .grant           (div_grant),
    .grant_km        (div_km),
    .busy            (div_busy)
  );

  assign bus.req_issued = grant;
  assign bus.fma_valid  = iss_q[CLS_FMA].vld;
  assign bus.fma_entry  = iss_q[CLS_FMA].entry;
  assign bus.div_valid  = iss_q[CLS_DIV].vld;
  assign bus.div_entry  = iss_q[CLS_DIV].entry;
  assign bus.misc_valid = iss_q[CLS_MISC].vld;
  assign bus.misc_entry = iss_q[CLS_MISC].entry;
  assign bus.div_busy   = div_busy;
endmodule

// File: tb/tb_fp_issue_sched.sv
// Scoreboard bench for fp_issue_sched: a virtual-time model of bus slots and
// divider occupancy predicts grants; a monitor checks unit issue outputs.
module tb_fp_issue_sched;
  localparam int NR = 2, EL = 32, SS = 4;
  localparam int FMA_L = 4, DIV_L = 12, MISC_L = 1;
  localparam int RESV_N = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_issue_sched_if #(.ISSUE_REQ(NR), .ENTRY_LEN(EL), .SPEC_STATES(SS)) bus();

  fp_issue_sched #(
    .ISSUE_REQ(NR), .ENTRY_LEN(EL), .SPEC_STATES(SS),
    .FMA_LAT(FMA_L), .DIV_LAT(DIV_L), .MISC_LAT(MISC_L)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef logic [EL-1:0] ent_t;

  int total = 0, bad = 0;
  // Model state in virtual time (advances only on unstalled cycles).
  int vt, div_free;
  logic [SS-1:0] div_km;
  bit   resv [0:RESV_N-1];
  ent_t expq [3][$];
  string un [3] = '{"fma", "div", "misc"};

  logic [NR-1:0]         s_v, iss, exp_iss;
  logic [NR-1:0][1:0]    s_c;
  logic [NR-1:0][SS-1:0] s_km;
  logic                  s_st, s_fl, s_ke, s_uk;
  logic [SS-1:0]         s_tag;
  int                    first;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [1:0] c);
    return (c == 2'b00) ? FMA_L : (c == 2'b01) ? DIV_L : MISC_L;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < RESV_N; i++) resv[i] = 1'b0;
    vt = 0; div_free = 0; div_km = '0;
    for (int u = 0; u < 3; u++) expq[u].delete();
  endtask

  task automatic clr_stim();
    s_v = '0; s_c = '0; s_km = '0;
    s_st = 0; s_fl = 0; s_ke = 0; s_uk = 0; s_tag = '0;
  endtask

  // One clock of stimulus: drive at negedge, predict grants, compare req_issued.
  task automatic cyc();
    logic [3:0] tk;
    bit busy_now, kill_div, ufree;
    int s, vt_next;
    @(negedge clk);
    chk("div_busy", bus.div_busy, vt < div_free);
    bus.stall = s_st; bus.flush = s_fl; bus.kill_en = s_ke; bus.update_killmask = s_uk;
    bus.fubr_spectag = s_tag; bus.req_valid = s_v; bus.req_class = s_c; bus.req_killmask = s_km;
    for (int p = 0; p < NR; p++) bus.req_entry[p] = EL'($urandom);
    #1;
    exp_iss  = '0;
    tk       = '0;
    busy_now = vt < div_free;
    kill_div = s_ke && busy_now && |(div_km & s_tag);
    if (!s_st && !s_fl)
      for (int p = 0; p < NR; p++)
        if (s_v[p] && s_c[p] != 2'b11 && !(s_ke && |(s_km[p] & s_tag))) begin
          s = vt + 1 + lat_of(s_c[p]);
          ufree = (s_c[p] == 2'b01) ? (!busy_now && !tk[1]) : !tk[s_c[p]];
          if (ufree && !resv[s]) begin
            exp_iss[p] = 1'b1;
            tk[s_c[p]] = 1'b1;
            resv[s]    = 1'b1;
            expq[s_c[p]].push_back(bus.req_entry[p]);
            if (s_c[p] == 2'b01) begin
              div_free = vt + DIV_L + 1;
              div_km   = s_km[p];
            end
          end
        end
    iss = bus.req_issued;
    chk("req_issued", iss, exp_iss);
    vt_next = s_st ? vt : vt + 1;
    if (kill_div) div_free = vt_next;
    if (s_uk) div_km = div_km & ~s_tag;
    if (s_fl) mdl_clear();
    else vt = vt_next;
  endtask

  task automatic idle(input int n);
    clr_stim();
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic div_req(input logic [SS-1:0] km);
    clr_stim(); s_v = 2'b01; s_c[0] = 2'b01; s_km[0] = km;
  endtask

  // Monitor: after every updating edge, each unit output must match the model.
  initial begin
    logic vv;
    ent_t ee;
    bit   ev;
    forever begin
      @(posedge clk); #2;
      if (rst_n && !bus.stall) begin
        for (int u = 0; u < 3; u++) begin
          case (u)
            0:       begin vv = bus.fma_valid;  ee = bus.fma_entry;  end
            1:       begin vv = bus.div_valid;  ee = bus.div_entry;  end
            default: begin vv = bus.misc_valid; ee = bus.misc_entry; end
          endcase
          ev = expq[u].size() != 0;
          chk({un[u], "_valid"}, vv, ev);
          if (vv && ev) chk({un[u], "_entry"}, ee, expq[u][0]);
          if (ev) void'(expq[u].pop_front());
        end
      end
    end
  end

  initial begin
    clr_stim();
    bus.stall = 0; bus.flush = 0; bus.kill_en = 0; bus.update_killmask = 0;
    bus.fubr_spectag = '0; bus.req_valid = '0; bus.req_class = '0;
    bus.req_killmask = '0; bus.req_entry = '0;
    mdl_clear();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_fma_valid", bus.fma_valid, 0);
    chk("rst_div_valid", bus.div_valid, 0);
    chk("rst_misc_valid", bus.misc_valid, 0);
    chk("rst_div_busy", bus.div_busy, 0);
    chk("rst_div_entry", bus.div_entry, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Two FMAs in one cycle: port 0 now, port 1 next cycle.
    clr_stim(); s_v = 2'b11; cyc();
    chk("two_fma_grant", iss, 2'b01);
    clr_stim(); s_v = 2'b10; cyc();
    chk("fma_port1_next", iss, 2'b10);
    idle(6);

    // Back-to-back DIV spacing.
    div_req('0); cyc();
    chk("div_first", iss, 2'b01);
    first = -1;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      chk("div_busy_window", bus.div_busy, k <= 12);
      if (iss[0] && first < 0) first = k;
    end
    chk("div_regrant_cycle", first, 13);
    idle(14);

    // FMA colliding with DIV writeback slot.
    div_req('0); cyc();
    idle(7);
    clr_stim(); s_v = 2'b01; s_c[0] = 2'b00; cyc();
    chk("fma_wb_conflict", iss, 2'b00);
    cyc();
    chk("fma_after_conflict", iss, 2'b01);
    idle(14);

    // Mispredict kills the in-flight DIV.
    div_req(4'b0010); cyc();
    idle(2);
    clr_stim(); s_ke = 1; s_tag = 4'b0010; cyc();
    div_req('0); cyc();
    chk("div_busy_after_kill", bus.div_busy, 0);
    chk("div_after_kill", iss, 2'b01);
    idle(14);

    // Stall freezes the divider counter.
    div_req('0); cyc();
    first = -1;
    for (int k = 1; k <= 24; k++) begin
      clr_stim(); s_st = (k >= 6 && k <= 8); cyc();
      if (!bus.div_busy && first < 0) first = k;
    end
    chk("div_stall_release", first, 16);
    idle(2);

    // Asynchronous reset mid-operation.
    clr_stim(); s_v = 2'b11; s_c[0] = 2'b01; s_c[1] = 2'b10; cyc();
    chk("div_misc_grant", iss, 2'b11);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_div_valid", bus.div_valid, 0);
    chk("arst_misc_valid", bus.misc_valid, 0);
    chk("arst_misc_entry", bus.misc_entry, 0);
    chk("arst_div_busy", bus.div_busy, 0);
    chk("arst_req_issued", bus.req_issued, 0);
    mdl_clear();
    @(posedge clk); #3 rst_n = 1'b1;
    clr_stim(); s_v = 2'b01; s_c[0] = 2'b10; cyc();
    chk("misc_after_reset", iss, 2'b01);
    idle(3);

    // Flush drops the in-flight DIV and blocks same-cycle grants.
    div_req('0); cyc();
    idle(3);
    clr_stim(); s_fl = 1; s_v = 2'b01; cyc();
    chk("flush_no_grant", iss, 2'b00);
    div_req('0); cyc();
    chk("div_after_flush", iss, 2'b01);
    idle(14);

    // Illegal class, and same-cycle kill of a matching request.
    clr_stim(); s_v = 2'b01; s_c[0] = 2'b11; cyc();
    chk("illegal_class", iss, 2'b00);
    clr_stim(); s_v = 2'b11; s_c[1] = 2'b10; s_km[0] = 4'b0100; s_km[1] = 4'b0001;
    s_ke = 1; s_tag = 4'b0100; cyc();
    chk("kill_same_cycle", iss, 2'b10);
    idle(2);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      clr_stim();
      s_v = NR'($urandom);
      for (int p = 0; p < NR; p++) begin
        s_c[p]  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        s_km[p] = SS'($urandom);
      end
      s_st = ($urandom_range(0, 7) == 0);
      s_fl = ($urandom_range(0, 63) == 0);
      if (!s_st) s_ke = ($urandom_range(0, 9) == 0);
      if (!s_ke) s_uk = ($urandom_range(0, 9) == 0);
      s_tag = SS'(1) << $urandom_range(0, SS - 1);
      cyc();
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_issue_sched.md
FP_ISSUE_SCHED -- requirements
Module: fp_issue_sched

Interface
REQ-001 Parameter ISSUE_REQ, default 2: number of FP reservation-station issue-request ports; port 0 is the oldest.
REQ-002 Parameter ENTRY_LEN, default `RS_FPU_LEN: width of one issue entry.
REQ-003 Parameter SPEC_STATES, default `SPEC_STATES: kill-mask width.
REQ-004 Parameters FMA_LAT=4, DIV_LAT=12, MISC_LAT=1: cycles from unit issue to writeback.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  core clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 stall  in  1  freeze all state; no grants.
REQ-009 flush  in  1  synchronous clear of all state.
REQ-010 kill_en  in  1  branch mispredict; kill ops whose killmask ANDed with fubr_spectag is nonzero.
REQ-011 update_killmask  in  1  branch resolved correctly; clear fubr_spectag bits in held killmasks.
REQ-012 fubr_spectag  in  SPEC_STATES  resolving branch tag.
REQ-013 req_valid  in  ISSUE_REQ  issue request valid per port.
REQ-014 req_entry  in  ISSUE_REQ*ENTRY_LEN  requested entries, packed.
REQ-015 req_class  in  ISSUE_REQ*2  per-port class: 00 FMA, 01 DIV/SQRT, 10 MISC, 11 illegal (never granted).
REQ-016 req_killmask  in  ISSUE_REQ*SPEC_STATES  per-port killmask.
REQ-017 req_issued  out  ISSUE_REQ  combinational grant; the RS invalidates the entry on the next clock.
REQ-018 fma_valid/fma_entry, div_valid/div_entry, misc_valid/misc_entry  out  1/ENTRY_LEN each  registered unit issue.
REQ-019 div_busy  out  1  iterative divider occupied.

Function
REQ-020 Grant is same-cycle; the granted entry appears on the unit output exactly 1 cycle later (issue stage at t+1). Its result occupies the shared FP writeback bus at t+1+LAT.
REQ-021 A 32-bit writeback reservation vector (DIV_LAT+2 bits used) has bit k set when the bus is taken at t+k. The vector shifts down 1 each unstalled cycle. A grant sets bit 1+LAT.
REQ-022 A request is granted only if all of the following hold: req_valid; class is legal; its unit is free; reservation bit 1+LAT is clear, including bits set by lower-numbered ports in the same cycle.
REQ-023 Unit freedom:
 - FMA is pipelined and accepts one grant per cycle.
 - MISC accepts one grant per cycle.
 - DIV is free only when div_busy=0 and no DIV is granted by a lower port this cycle.
REQ-024 Ports are evaluated in index order. A denied lower port does not block a higher port (out-of-order grant allowed).
REQ-025 DIV grant sets div_busy and loads a down-counter with DIV_LAT. The counter decrements each unstalled cycle. div_busy clears when the counter reaches 0. Back-to-back DIV issue is therefore spaced by DIV_LAT+1 cycles.
REQ-026 Held killmasks (issue-stage regs and the in-flight DIV) update on update_killmask.
REQ-027 kill_en with a matching killmask:
 - issue-stage valid drops before it is presented;
 - an in-flight DIV clears div_busy and the counter next cycle;
 - reservation bits are not released (conservative).
REQ-028 Same-cycle kill_en and grant: a request whose own req_killmask matches is not granted.
REQ-029 stall=1: req_issued=0; vector, counter and issue regs hold; unit outputs hold their values.
REQ-030 flush has priority over stall and kill; all state and outputs go to 0 next cycle.

Reset
REQ-031 rst_n low asynchronously clears:
 - all *_valid, req_issued, div_busy;
 - the reservation vector and the DIV counter;
 - all *_entry outputs to 0.
REQ-032 Reset mid-DIV abandons the operation; the first cycle after release accepts any grant.

Configuration
REQ-033 With FP_SCHED_PERFCNT_EN defined:
 - outputs perf_struct_stall[31:0] and perf_wb_conflict[31:0] are present;
 - each counts request-cycles denied for unit-busy or writeback-slot respectively;
 - counters wrap, are not cleared by flush, and are cleared by reset.
 Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Structure
REQ-034 Shared package fp_sched_pkg holds the class encodings, the latency constants and the reservation-vector width.
REQ-035 Sub-module fp_div_tracker contains the DIV counter, busy flag and killmask; everything else stays flat.

Verification
REQ-036 Two FMA requests in one cycle -> req_issued=01; port 1 is granted the next cycle; fma_valid on consecutive cycles.
REQ-037 DIV granted at t, then DIV requested each cycle -> denied until t+13, granted at t+13; div_busy high t+1..t+12.
REQ-038 DIV granted at t (wb t+13), FMA requested at t+8 (wb t+13) -> denied; granted at t+9.
REQ-039 DIV in flight with killmask 0010, kill_en with fubr_spectag 0010 -> div_busy=0 next cycle; a new DIV is granted the following cycle.
REQ-040 stall asserted 3 cycles mid-DIV -> counter frozen; div_busy clears 3 cycles later than without stall.
REQ-041 rst_n pulsed low mid-operation -> outputs zero immediately; a new MISC request is granted on the first cycle after release.
